// File: rtl/detector_permanencia_setor.sv
// Sector dwell detector for the pendulum LED ring.
// An attempt starts on a target sector, waits until the pendulum enters the
// sector's strict window (SEEK). It then requires DWELL_CYCLES consecutive
// cycles inside a hysteresis-widened window (DWELL) to report a hit.
// Every attempt is bounded by TIMEOUT_CYCLES busy cycles.
module detector_permanencia_setor #(
  parameter int TOTAL_RANGE_STEPS16 = 3200,
  parameter int NUM_SETORES         = 11,
  parameter int POS_WIDTH           = 16,
  parameter int DWELL_CYCLES        = 50_000_000,
  parameter int TIMEOUT_CYCLES      = 500_000_000,
  parameter int HYST                = 16,
  localparam int LED_W = (NUM_SETORES > 1) ? $clog2(NUM_SETORES) : 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [LED_W-1:0]            position_led,
  input  logic signed [POS_WIDTH-1:0] current_position,
  output logic                        isInPosition,
  output logic                        busy,
  output logic                        hit,
  output logic                        timeout,
  output logic                        erro_led
);

  localparam int SETOR_SIZE = TOTAL_RANGE_STEPS16 / NUM_SETORES;
  // Bound arithmetic is wide enough that neither the position nor the
  // widened sector edges can wrap.
  localparam int BW_POS = POS_WIDTH + 8;
  localparam int BW_RNG = $clog2(TOTAL_RANGE_STEPS16 + HYST + 1) + 2;
  localparam int BW     = (BW_POS > BW_RNG) ? BW_POS : BW_RNG;
  localparam int DW_W   = $clog2(DWELL_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic signed [BW-1:0] SETOR_S = BW'(SETOR_SIZE);
  localparam logic signed [BW-1:0] HYST_S  = BW'(HYST);

  typedef enum logic [1:0] {IDLE, SEEK, DWELL} state_t;

  state_t                      state;
  logic signed [POS_WIDTH-1:0] pos_q;
  logic signed [BW-1:0]        lo_q;
  logic signed [BW-1:0]        hi_q;
  logic [DW_W-1:0]             dwell_cnt;
  logic [TO_W-1:0]             att_cnt;

  logic signed [BW-1:0] pos_ext;
  logic signed [BW-1:0] led_s;
  logic signed [BW-1:0] lo_new;
  logic signed [BW-1:0] hi_new;
  logic                 led_ok;
  logic                 in_strict_new;
  logic                 in_strict;
  logic                 in_hyst;
  logic [TO_W-1:0]      att_next;
  logic                 dwell_done;
  logic                 timed_out;

  // Sector bounds, window compares and counter terminal conditions.
  assign pos_ext       = {{(BW-POS_WIDTH){pos_q[POS_WIDTH-1]}}, pos_q};
  assign led_s         = BW'(position_led);
  assign lo_new        = led_s * SETOR_S;
  assign hi_new        = lo_new + SETOR_S;
  assign led_ok        = {1'b0, position_led} < (LED_W+1)'(NUM_SETORES);
  assign in_strict_new = (pos_ext >= lo_new) && (pos_ext < hi_new);
  assign in_strict     = (pos_ext >= lo_q) && (pos_ext < hi_q);
  assign in_hyst       = (pos_ext >= lo_q - HYST_S) && (pos_ext < hi_q + HYST_S);
  assign att_next      = att_cnt + TO_W'(1);
  assign dwell_done    = dwell_cnt == DW_W'(DWELL_CYCLES - 1);
  assign timed_out     = att_next == TO_W'(TIMEOUT_CYCLES);

  // Position sample register; every window compare uses this copy.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state is written with <= so every register samples pre-edge values.
    if (!reset_n) pos_q <= '0;
    else          pos_q <= current_position;
  end

  // Attempt FSM with registered status and one-cycle result pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      dwell_cnt    <= '0;
      att_cnt      <= '0;
      isInPosition <= 1'b0;
      busy         <= 1'b0;
      hit          <= 1'b0;
      timeout      <= 1'b0;
      erro_led     <= 1'b0;
    end else begin
      hit      <= 1'b0;
      timeout  <= 1'b0;
      erro_led <= 1'b0;
      case (state)
        IDLE: begin
          busy         <= 1'b0;
          isInPosition <= 1'b0;
          // Abort in IDLE suppresses a simultaneous start entirely.
          if (start && !abort) begin
            if (led_ok) begin
              // The target sector is held as its bounds; the index itself
              // is not needed again during the attempt.
              lo_q         <= lo_new;
              hi_q         <= hi_new;
              dwell_cnt    <= '0;
              att_cnt      <= '0;
              state        <= SEEK;
              busy         <= 1'b1;
              isInPosition <= in_strict_new;
            end else begin
              erro_led <= 1'b1;
            end
          end
        end

        SEEK, DWELL: begin
          att_cnt <= att_next;
          if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            isInPosition <= 1'b0;
          end else if (state == DWELL && in_hyst && dwell_done) begin
            // A hit on the last allowed cycle wins over the timeout.
            state        <= IDLE;
            busy         <= 1'b0;
            isInPosition <= 1'b0;
            hit          <= 1'b1;
          end else if (timed_out) begin
            state        <= IDLE;
            busy         <= 1'b0;
            isInPosition <= 1'b0;
            timeout      <= 1'b1;
          end else begin
            isInPosition <= in_strict;
            if (state == SEEK) begin
              if (in_strict) begin
                state     <= DWELL;
                dwell_cnt <= '0;
              end
            end else if (!in_hyst) begin
              state     <= SEEK;
              dwell_cnt <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + DW_W'(1);
            end
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          isInPosition <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detector_permanencia_setor.sv
// Directed bench for detector_permanencia_setor with small dwell/timeout
// parameters. Sector 3 strict window is [870,1160), hysteresis [865,1165).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_detector_permanencia_setor;

  localparam int LED_W = 4;

  logic                clock;
  logic                reset_n;
  logic                start;
  logic                abort;
  logic [LED_W-1:0]    position_led;
  logic signed [15:0]  current_position;
  logic                isInPosition;
  logic                busy;
  logic                hit;
  logic                timeout;
  logic                erro_led;

  int checks;
  int failures;

  detector_permanencia_setor #(
    .TOTAL_RANGE_STEPS16(3200),
    .NUM_SETORES        (11),
    .POS_WIDTH          (16),
    .DWELL_CYCLES       (4),
    .TIMEOUT_CYCLES     (20),
    .HYST               (5)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .position_led    (position_led),
    .current_position(current_position),
    .isInPosition    (isInPosition),
    .busy            (busy),
    .hit             (hit),
    .timeout         (timeout),
    .erro_led        (erro_led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Packs all five outputs as {isInPosition,busy,hit,timeout,erro_led}.
  function automatic logic [31:0] outs();
    return {27'd0, isInPosition, busy, hit, timeout, erro_led};
  endfunction

  initial begin
    checks           = 0;
    failures         = 0;
    reset_n          = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    position_led     = '0;
    current_position = '0;

    // Reset state.
    tick();
    tick();
    check("reset_outputs", outs(), 32'b00000);
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", outs(), 32'b00000);

    // Basic hit: led 3, position held at 1000.
    current_position = 16'sd1000;
    tick();
    start = 1'b1; position_led = 4'd3;
    tick();                                    // accepted -> SEEK
    start = 1'b0;
    check("hit_busy_in_pos", outs(), 32'b11000);
    for (int i = 1; i <= 4; i++) begin
      tick();                                  // SEEK->DWELL, then dwell 0..2
      check("hit_waiting", outs(), 32'b11000);
    end
    tick();                                    // dwell count 3 -> hit
    check("hit_pulse", outs(), 32'b00100);
    tick();
    check("hit_one_cycle", outs(), 32'b00000);

    // Mid-dwell move to 1162: inside hysteresis only, dwell continues.
    start = 1'b1;
    tick();                                    // E0
    start = 1'b0;
    tick();                                    // E1 -> DWELL
    current_position = 16'sd1162;
    tick();                                    // E2: dwell 1, pos_q <= 1162
    check("hyst_in_pos_old", outs(), 32'b11000);
    tick();                                    // E3: pos 1162 kept in DWELL
    check("hyst_not_strict", outs(), 32'b01000);
    tick();                                    // E4
    check("hyst_still_dwell", outs(), 32'b01000);
    tick();                                    // E5: hit
    check("hyst_hit", outs(), 32'b00100);

    // Mid-dwell move to 1166: leaves hysteresis, dwell restarts.
    current_position = 16'sd1000;
    tick();
    start = 1'b1;
    tick();                                    // E0
    start = 1'b0;
    tick();                                    // E1 -> DWELL
    current_position = 16'sd1166;
    tick();                                    // E2
    tick();                                    // E3: back to SEEK
    check("exit_to_seek", outs(), 32'b01000);
    current_position = 16'sd1000;
    for (int i = 4; i <= 8; i++) begin
      tick();
      check("restart_no_early_hit", {31'd0, hit}, 32'd0);
    end
    tick();                                    // E9: restarted dwell finishes
    check("restart_hit", outs(), 32'b00100);

    // Timeout with position outside the sector; start mid-attempt ignored.
    current_position = 16'sd500;
    tick();
    start = 1'b1; position_led = 4'd3;
    tick();                                    // E0
    start = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      if (i == 5) begin start = 1'b1; position_led = 4'd11; end
      if (i == 6) begin start = 1'b0; position_led = 4'd3; end
      tick();
      check("timeout_waiting", outs(), 32'b01000);
    end
    tick();                                    // E20: 20th busy cycle
    check("timeout_pulse", outs(), 32'b00010);
    tick();
    check("timeout_one_cycle", outs(), 32'b00000);

    // Invalid sector index.
    start = 1'b1; position_led = 4'd11;
    tick();
    start = 1'b0;
    check("erro_led_pulse", outs(), 32'b00001);
    tick();
    check("erro_led_one_cycle", outs(), 32'b00000);

    // Abort together with start in IDLE: nothing happens.
    start = 1'b1; abort = 1'b1; position_led = 4'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", outs(), 32'b00000);

    // Sector 0 lower edge: -1 outside, 0 inside.
    current_position = -16'sd1;
    tick();
    start = 1'b1; position_led = 4'd0;
    tick();
    start = 1'b0;
    check("led0_neg_out", outs(), 32'b01000);
    tick();
    tick();
    check("led0_neg_still_seek", outs(), 32'b01000);
    current_position = 16'sd0;
    tick();                                    // pos_q <= 0
    tick();                                    // SEEK sees 0 -> DWELL
    check("led0_zero_in", outs(), 32'b11000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_seek_idle", outs(), 32'b00000);

    // Abort during DWELL.
    current_position = 16'sd1000;
    tick();
    start = 1'b1; position_led = 4'd3;
    tick();                                    // E0
    start = 1'b0;
    tick();                                    // E1 -> DWELL
    tick();                                    // E2
    abort = 1'b1;
    tick();                                    // E3 -> IDLE
    abort = 1'b0;
    check("abort_dwell_idle", outs(), 32'b00000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_pulse", outs(), 32'b00000);
    end

    // Reset during SEEK, then immediate restart.
    current_position = 16'sd500;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_reset_busy", outs(), 32'b01000);
    current_position = 16'sd1000;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 32'b00000);
    tick();
    check("reset_held_outputs", outs(), 32'b00000);
    reset_n = 1'b1;
    start = 1'b1; position_led = 4'd3;
    tick();                                    // first edge after release
    start = 1'b0;
    check("restart_after_reset", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("restart_no_pulse", outs() & 32'b00111, 32'd0);
    end
    tick();
    check("restart_after_reset_hit", outs(), 32'b00100);

    // Dwell completes on the final allowed busy cycle: hit only.
    current_position = 16'sd500;
    tick();
    start = 1'b1;
    tick();                                    // E0
    start = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (i == 14) current_position = 16'sd1000;
    end
    check("race_before_end", outs(), 32'b11000);
    tick();                                    // E20
    check("race_hit_wins", outs(), 32'b00100);
    tick();
    check("race_quiet", outs(), 32'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
